mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified memory port between the multicycle core's two requesters.
//  The requesters are instruction fetch (IF state) and data access (lw/sw in MEM_RD/MEM_WR).
//  Round-robin arbitration, request latching, a wait-state handshake with memory and a timeout watchdog.
//  Sits between the control unit / datapath and the memory model; the control unit
//  holds its state until the matching *_done pulse.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width (DATA_W/8 byte strobes)
//  TIMEOUT  15  max ACCESS cycles without mem_ready before a bus error; >=1
// PORTS
//  clk        in   1        clock, rising edge
//  resetn     in   1        asynchronous reset, active low
//  if_req     in   1        fetch request; held until if_done
//  if_addr    in   ADDR_W   fetch address
//  if_gnt     out  1        fetch owns port (ACCESS/DONE)
//  if_done    out  1        1-cycle pulse: fetch complete
//  if_rdata   out  DATA_W   fetched word, valid while if_done=1
//  d_req      in   1        data request; held until d_done
//  d_we       in   1        1=store, 0=load
//  d_addr     in   ADDR_W   data address
//  d_wdata    in   DATA_W   store data
//  d_wstrb    in   DATA_W/8 store byte enables
//  d_gnt      out  1        data side owns port
//  d_done     out  1        1-cycle pulse: data access complete
//  d_rdata    out  DATA_W   load word, valid while d_done=1
//  bus_err    out  1        with *_done: access timed out
//  mem_valid  out  1        memory request active
//  mem_we     out  1        memory write enable
//  mem_addr   out  ADDR_W   memory address
//  mem_wdata  out  DATA_W   memory write data
//  mem_wstrb  out  DATA_W/8 memory byte enables (0 for reads)
//  mem_rdata  in   DATA_W   memory read data, sampled with mem_ready
//  mem_ready  in   1        memory completes access this cycle
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, last_owner=DATA (fetch wins first tie), wait_cnt=0.
//    All outputs are 0, including mem_valid, which drops mid-access.
//  FSM:
//    IDLE: if any req, grant the owner -> ACCESS.
//      Only one request: grant it.
//      Both requesting: grant the one != last_owner.
//      At the grant edge, register addr/we/wdata/wstrb into the mem_* outputs.
//      Fetch grants set mem_we=0 and wstrb=0.
//      Set last_owner to the granted requester and clear wait_cnt.
//    ACCESS: mem_valid=1 and the owner's gnt=1.
//      mem_ready=1 -> DONE; capture mem_rdata (0 on a write), err=0.
//      Otherwise, when wait_cnt==TIMEOUT-1 -> DONE with rdata=0, err=1.
//      Otherwise wait_cnt++.
//    DONE: mem_valid=0; owner's gnt=1 and owner's done=1 for exactly 1 cycle.
//      The owner's rdata carries the captured word; bus_err=err. Next state is IDLE.
//  Requester rule: drop req on the edge that samples *_done=1, so req is 0 in the following IDLE.
//  mem_* address/data stay stable for the whole ACCESS; requests arriving mid-access wait.
//  Min latency: req rising before edge N, mem_ready in first ACCESS cycle -> done in cycle N+2.
//    A port turnaround costs 1 IDLE cycle.
//  mem_ready outside ACCESS is ignored; a changing req/addr outside IDLE is ignored.
//  Exactly one gnt is high at a time; done/rdata are never driven for the non-owner (0).
// TESTING
//  1. Fetch only, mem_ready=1 immediately, addr 0x100, rdata 0x00500093
//     -> if_done one cycle, 2 cycles after req; if_rdata=0x00500093; mem_we=0.
//  2. Store d_addr=0x40, wdata=0xDEADBEEF, wstrb=4'hF, mem_ready after 3 waits
//     -> mem_* stable 4 cycles, mem_we=1; d_done with d_rdata=0 and bus_err=0.
//  3. Both req from reset -> fetch granted first, data next (1 IDLE gap).
//     Both again -> fetch (RR alternates).
//  4. mem_ready held 0, TIMEOUT=15 -> d_done + bus_err after 15 ACCESS cycles; d_rdata=0.
//  5. resetn low in the 2nd ACCESS cycle -> mem_valid, gnt, done go 0 at once.
//     After release, the next grant goes to fetch.
//  6. mem_ready pulsed in IDLE, then a load -> no spurious done.
//     The load waits for mem_ready inside ACCESS.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares the single unified memory port of the multicycle core between its
//   two requesters: instruction fetch and data access (load/store). Requests
//   are arbitrated round-robin, the winning request is latched onto the
//   memory port for the whole access, memory may insert wait states through
//   mem_ready, and a watchdog ends an access with a bus error if memory
//   never answers. The requester is told it has finished through a one-cycle
//   *_done pulse.
//
// Parameters:
//   ADDR_W   address width
//   DATA_W   data width (DATA_W/8 byte strobes)
//   TIMEOUT  max ACCESS cycles without mem_ready before a bus error (>= 1)
//
// Ports:
//   clk, resetn                 clock (rising edge), async active-low reset
//   if_req/if_addr              fetch request, held until if_done
//   if_gnt/if_done/if_rdata     fetch owns port / completion pulse / word
//   d_req/d_we/d_addr/d_wdata/d_wstrb
//                               data request (store when d_we=1)
//   d_gnt/d_done/d_rdata        data owns port / completion pulse / word
//   bus_err                     qualifies a *_done pulse: access timed out
//   mem_valid/mem_we/mem_addr/mem_wdata/mem_wstrb
//                               request towards memory
//   mem_rdata/mem_ready         response from memory
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_done,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_gnt,
    output logic                d_done,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                bus_err,
    output logic                mem_valid,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready
);

    localparam int STRB_W = DATA_W / 8;
    // Counter only has to reach TIMEOUT-1
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state;
    logic             owner_data;
    logic             last_data;
    logic [CNT_W-1:0] wait_cnt;
    logic             pick_data;

    // Round-robin choice: data wins when it is the only requester, or when
    // both request and fetch was the previous owner.
    assign pick_data = d_req & (~if_req | ~last_data);

    // Single FSM; every output is a register so nothing glitches towards
    // memory or the control unit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            owner_data <= 1'b0;
            last_data  <= 1'b1;
            wait_cnt   <= '0;
            if_gnt     <= 1'b0;
            if_done    <= 1'b0;
            if_rdata   <= '0;
            d_gnt      <= 1'b0;
            d_done     <= 1'b0;
            d_rdata    <= '0;
            bus_err    <= 1'b0;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        state      <= ACCESS;
                        owner_data <= pick_data;
                        last_data  <= pick_data;
                        wait_cnt   <= '0;
                        mem_valid  <= 1'b1;
                        if_gnt     <= ~pick_data;
                        d_gnt      <= pick_data;
                        if (pick_data) begin
                            mem_addr  <= d_addr;
                            mem_we    <= d_we;
                            mem_wdata <= d_wdata;
                            // Byte enables only mean something on a store
                            mem_wstrb <= d_we ? d_wstrb : {STRB_W{1'b0}};
                        end else begin
                            mem_addr  <= if_addr;
                            mem_we    <= 1'b0;
                            mem_wdata <= '0;
                            mem_wstrb <= '0;
                        end
                    end
                end

                ACCESS: begin
                    if (mem_ready) begin
                        state     <= DONE;
                        mem_valid <= 1'b0;
                        if_done   <= ~owner_data;
                        d_done    <= owner_data;
                        if_rdata  <= owner_data ? '0 : mem_rdata;
                        // A store returns no data
                        d_rdata   <= (owner_data && !mem_we) ? mem_rdata : '0;
                        bus_err   <= 1'b0;
                    end else if (wait_cnt == LAST_CNT) begin
                        state     <= DONE;
                        mem_valid <= 1'b0;
                        if_done   <= ~owner_data;
                        d_done    <= owner_data;
                        if_rdata  <= '0;
                        d_rdata   <= '0;
                        bus_err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                DONE: begin
                    state    <= IDLE;
                    if_gnt   <= 1'b0;
                    d_gnt    <= 1'b0;
                    if_done  <= 1'b0;
                    d_done   <= 1'b0;
                    if_rdata <= '0;
                    d_rdata  <= '0;
                    bus_err  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Purpose:
//   Self-checking bench for mem_port_arbiter. Requester tasks issue fetch and
//   data transactions and push the expected completion into per-requester
//   queues; a negedge monitor acts as the memory model, checks the memory
//   port, arbitration order and completions against those queues.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        resetn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_gnt;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        bus_err;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          waits;
        logic [31:0] rdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } txn_t;

    txn_t if_q[$];
    txn_t d_q[$];

    mem_port_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_done  (if_done),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_wstrb  (d_wstrb),
        .d_gnt    (d_gnt),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .bus_err  (bus_err),
        .mem_valid(mem_valid),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Expected completion: memory answers after 'waits' wait cycles unless
    // that is TIMEOUT or more, in which case the watchdog fires first.
    function automatic txn_t make_txn(input logic we, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [3:0] wstrb,
                                      input int waits, input logic [31:0] rdata);
        txn_t t;
        t.we        = we;
        t.addr      = addr;
        t.wdata     = wdata;
        t.wstrb     = wstrb;
        t.waits     = waits;
        t.rdata     = rdata;
        t.exp_err   = (waits >= TIMEOUT);
        t.exp_rdata = (t.exp_err || we) ? 32'h0 : rdata;
        return t;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_ctrl"},
                     {57'h0, if_gnt, if_done, d_gnt, d_done, bus_err, mem_valid, mem_we}, 64'h0);
        check_output({tag, "_rdata"}, {if_rdata, d_rdata}, 64'h0);
        check_output({tag, "_mem"}, {mem_addr, mem_wdata}, 64'h0);
        check_output({tag, "_wstrb"}, {60'h0, mem_wstrb}, 64'h0);
    endtask

    // Fetch requester: raise request, wait for if_done, drop on that edge.
    task automatic run_fetch(input logic [31:0] addr, input int waits,
                             input logic [31:0] rdata, output int lat);
        bit got;
        if_q.push_back(make_txn(1'b0, addr, 32'h0, 4'h0, waits, rdata));
        if_addr = addr;
        if_req  = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            got = if_done;
        end
        check_output("if_done_seen", {63'h0, got}, 64'h1);
        @(posedge clk);
        #1;
        if_req  = 1'b0;
        if_addr = $urandom;
    endtask

    // Data requester: same handshake as fetch with store/load fields.
    task automatic run_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input int waits,
                            input logic [31:0] rdata, output int lat);
        bit got;
        d_q.push_back(make_txn(we, addr, wdata, wstrb, waits, rdata));
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        d_wstrb = wstrb;
        d_req   = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            got = d_done;
        end
        check_output("d_done_seen", {63'h0, got}, 64'h1);
        @(posedge clk);
        #1;
        d_req   = 1'b0;
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_we    = $urandom_range(0, 1);
    endtask

    function automatic int random_waits();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)       return $urandom_range(0, 4);
        else if (r == 7) return TIMEOUT - 1;
        else if (r == 8) return TIMEOUT;
        else             return TIMEOUT + 5;
    endfunction

    // Memory model and scoreboard monitor. mem_ready is held high outside an
    // access so any reaction to it there shows up as a spurious completion.
    initial begin : monitor
        logic prev_valid;
        logic prev_if_req;
        logic prev_d_req;
        logic model_last_data;
        logic cur_data;
        logic have_cur;
        logic bad;
        int   cnt;
        txn_t cur;
        txn_t t;
        prev_valid      = 1'b0;
        prev_if_req     = 1'b0;
        prev_d_req      = 1'b0;
        model_last_data = 1'b1;
        cur_data        = 1'b0;
        have_cur        = 1'b0;
        cnt             = 0;
        mem_ready       = 1'b0;
        mem_rdata       = 32'h0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_valid      = 1'b0;
                model_last_data = 1'b1;
                have_cur        = 1'b0;
                cnt             = 0;
                mem_ready       = 1'b0;
                prev_if_req     = if_req;
                prev_d_req      = d_req;
                continue;
            end

            bad = (if_gnt && d_gnt) || (if_done && d_done) || (if_done && !if_gnt) ||
                  (d_done && !d_gnt) || (!if_done && if_rdata != 32'h0) ||
                  (!d_done && d_rdata != 32'h0) || (bus_err && !(if_done || d_done)) ||
                  (mem_valid && !(if_gnt || d_gnt));
            check_output("invariants", {63'h0, bad}, 64'h0);

            if (mem_valid && !prev_valid) begin
                if (prev_if_req && prev_d_req) cur_data = !model_last_data;
                else                           cur_data = prev_d_req;
                check_output("req_before_grant", {63'h0, prev_if_req | prev_d_req}, 64'h1);
                check_output("grant_owner", {62'h0, if_gnt, d_gnt},
                             cur_data ? 64'h1 : 64'h2);
                model_last_data = cur_data;
                have_cur = cur_data ? (d_q.size() > 0) : (if_q.size() > 0);
                check_output("plan_present", {63'h0, have_cur}, 64'h1);
                if (have_cur) cur = cur_data ? d_q[0] : if_q[0];
                cnt = 0;
            end

            if (mem_valid) begin
                if (have_cur) begin
                    check_output("mem_addr", {32'h0, mem_addr}, {32'h0, cur.addr});
                    check_output("mem_we", {63'h0, mem_we}, {63'h0, cur.we});
                    check_output("mem_wstrb", {60'h0, mem_wstrb},
                                 {60'h0, (cur.we ? cur.wstrb : 4'h0)});
                    if (cur.we) check_output("mem_wdata", {32'h0, mem_wdata}, {32'h0, cur.wdata});
                    mem_ready = (cnt == cur.waits);
                    mem_rdata = mem_ready ? cur.rdata : $urandom;
                end else begin
                    mem_ready = 1'b1;
                    mem_rdata = $urandom;
                end
                cnt++;
            end else begin
                mem_ready = 1'b1;
                mem_rdata = $urandom;
            end

            if (if_done) begin
                check_output("if_done_after_access", {63'h0, prev_valid}, 64'h1);
                if (if_q.size() == 0) begin
                    check_output("if_done_expected", {63'h0, if_done}, 64'h0);
                end else begin
                    t = if_q.pop_front();
                    check_output("if_rdata", {32'h0, if_rdata}, {32'h0, t.exp_rdata});
                    check_output("if_bus_err", {63'h0, bus_err}, {63'h0, t.exp_err});
                    check_output("if_access_cycles", 64'(cnt),
                                 64'(t.exp_err ? TIMEOUT : t.waits + 1));
                end
                have_cur = 1'b0;
            end
            if (d_done) begin
                check_output("d_done_after_access", {63'h0, prev_valid}, 64'h1);
                if (d_q.size() == 0) begin
                    check_output("d_done_expected", {63'h0, d_done}, 64'h0);
                end else begin
                    t = d_q.pop_front();
                    check_output("d_rdata", {32'h0, d_rdata}, {32'h0, t.exp_rdata});
                    check_output("d_bus_err", {63'h0, bus_err}, {63'h0, t.exp_err});
                    check_output("d_access_cycles", 64'(cnt),
                                 64'(t.exp_err ? TIMEOUT : t.waits + 1));
                end
                have_cur = 1'b0;
            end

            prev_valid  = mem_valid;
            prev_if_req = if_req;
            prev_d_req  = d_req;
        end
    end

    // Directed scenarios first, then randomized contention, then reset
    // in the middle of an access.
    initial begin : apply_stimulus
        int la;
        int lb;
        resetn  = 1'b0;
        if_req  = 1'b0;
        if_addr = 32'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        d_wstrb = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        resetn = 1'b1;

        // Both requesting from reset: fetch first, data after one idle gap
        fork
            run_fetch(32'h0000_0200, 0, 32'h1111_2222, la);
            run_data(1'b0, 32'h0000_0300, 32'h0, 4'h0, 0, 32'h3333_4444, lb);
        join
        check_output("both_fetch_latency", 64'(la), 64'd2);
        check_output("both_data_latency", 64'(lb), 64'd5);

        // Both again: last owner was data, so fetch wins again
        fork
            run_fetch(32'h0000_0204, 1, 32'h5555_6666, la);
            run_data(1'b1, 32'h0000_0304, 32'hCAFE_F00D, 4'h3, 0, 32'h7777_8888, lb);
        join
        check_output("rr_fetch_latency", 64'(la), 64'd3);
        check_output("rr_data_latency", 64'(lb), 64'd6);

        // Lone fetch with an immediate answer
        run_fetch(32'h0000_0100, 0, 32'h0050_0093, la);
        check_output("fetch_min_latency", 64'(la), 64'd2);

        // Store with three wait states
        run_data(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 3, 32'h9999_AAAA, lb);
        check_output("store_latency", 64'(lb), 64'd5);

        // Load that memory never answers: watchdog ends it
        run_data(1'b0, 32'h0000_0080, 32'h0, 4'hA, 100, 32'hBBBB_CCCC, lb);
        check_output("timeout_latency", 64'(lb), 64'(TIMEOUT + 1));

        // Load after mem_ready was high during idle: must wait in ACCESS
        run_data(1'b0, 32'h0000_0084, 32'h0, 4'h5, 2, 32'h1234_5678, lb);
        check_output("load_wait_latency", 64'(lb), 64'd4);

        // Randomized traffic from both requesters
        fork
            begin
                int n;
                for (int i = 0; i < 30; i++) begin
                    n = $urandom_range(0, 3);
                    repeat (n) @(posedge clk);
                    #1;
                    run_fetch($urandom & 32'hFFFF_FFFC, random_waits(), $urandom, la);
                end
            end
            begin
                int n;
                for (int j = 0; j < 30; j++) begin
                    n = $urandom_range(0, 3);
                    repeat (n) @(posedge clk);
                    #1;
                    run_data(1'($urandom_range(0, 1)), $urandom, $urandom,
                             4'($urandom_range(1, 15)), random_waits(), $urandom, lb);
                end
            end
        join

        // Reset during the second ACCESS cycle of a load
        @(posedge clk);
        #1;
        d_q.push_back(make_txn(1'b0, 32'h0000_0500, 32'h0, 4'h0, 100, 32'h0));
        d_we   = 1'b0;
        d_addr = 32'h0000_0500;
        d_req  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_output("access_before_reset", {62'h0, mem_valid, d_gnt}, 64'h3);
        resetn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        d_req = 1'b0;
        d_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        fork
            run_fetch(32'h0000_0600, 0, 32'hABCD_0001, la);
            run_data(1'b0, 32'h0000_0700, 32'h0, 4'h0, 0, 32'hABCD_0002, lb);
        join
        check_output("post_reset_fetch_first", 64'(la), 64'd2);
        check_output("post_reset_data_second", 64'(lb), 64'd5);

        repeat (3) @(posedge clk);
        #1;
        check_output("if_queue_drained", 64'(if_q.size()), 64'd0);
        check_output("d_queue_drained", 64'(d_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
